// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared types and constants for the block-memory responder
package data_memory_responder_pkg;
    localparam int BLOCK_WIDTH        = 128;
    localparam int ADDR_WIDTH         = 28;
    localparam int DEFAULT_LATENCY    = 5;
    localparam int DEFAULT_INDEX_BITS = 8;
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;
endpackage

// File: rtl/data_mem_block_array.sv
// data_mem_block_array: 2^INDEX_BITS x 128-bit storage, sync write, registered read
// Ports: clk_i/rst_i clock and sync reset (clears only the read register),
//        we_i/re_i write/read enables, idx_i block index, wdata_i write block,
//        rdata_o registered read block (held until the next read)
module data_mem_block_array
    import data_memory_responder_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [INDEX_BITS-1:0]  idx_i,
    input  logic [BLOCK_WIDTH-1:0] wdata_i,
    output logic [BLOCK_WIDTH-1:0] rdata_o
);
    logic [BLOCK_WIDTH-1:0] mem_q [2**INDEX_BITS];
    logic [BLOCK_WIDTH-1:0] rdata_q;
    // storage is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[idx_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency 128-bit block memory with busywait handshake
// Ports: CLK/RESET clock and sync active-high reset, READ/WRITE request strobes,
//        ADDRESS block address (low INDEX_BITS used), WRITEDATA write block,
//        READDATA last read block, BUSYWAIT high while a request is pending
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   READ,
    input  logic                   WRITE,
    input  logic [ADDR_WIDTH-1:0]  ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] READDATA,
    output logic                   BUSYWAIT
);
    // counter value seen on the final BUSY edge; the accept edge counts as the first latency edge
    localparam logic [3:0] LAST = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [INDEX_BITS-1:0]  idx_q, idx_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
    logic                   accept, complete, op_wr, mem_we, mem_re;
    logic [INDEX_BITS-1:0]  op_idx;
    logic [BLOCK_WIDTH-1:0] op_wdata;
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[ADDR_WIDTH-1:INDEX_BITS];
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        wr_q    <= wr_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end
    always_comb begin
        accept   = (state_q == IDLE) && (READ || WRITE);
        // with LATENCY 1 the accept edge is also the completion edge, so live inputs feed the array
        complete = (accept && LATENCY == 1) || (state_q == BUSY && cnt_q == LAST);
        state_d  = (state_q == IDLE) ? (accept ? (LATENCY == 1 ? ACK : BUSY) : IDLE) :
                   (state_q == BUSY) ? (complete ? ACK : BUSY) : IDLE;
        cnt_d    = accept ? 4'd0 : (state_q == BUSY) ? cnt_q + 4'd1 : cnt_q;
        wr_d     = accept ? WRITE : wr_q;
        idx_d    = accept ? ADDRESS[INDEX_BITS-1:0] : idx_q;
        wdata_d  = accept ? WRITEDATA : wdata_q;
    end
    always_comb begin
        BUSYWAIT = (state_q == IDLE) ? (READ || WRITE) : (state_q == BUSY);
        op_wr    = (state_q == IDLE) ? WRITE : wr_q;
        op_idx   = (state_q == IDLE) ? ADDRESS[INDEX_BITS-1:0] : idx_q;
        op_wdata = (state_q == IDLE) ? WRITEDATA : wdata_q;
        mem_we   = complete && op_wr && !RESET;
        mem_re   = complete && !op_wr && !RESET;
    end
    data_mem_block_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (op_idx),
        .wdata_i (op_wdata),
        .rdata_o (READDATA)
    );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed and random checks of the responder against a transaction model
module tb_data_memory_responder;
    logic         clk, rst;
    logic         rd5, wr5, rd1, wr1;
    logic [27:0]  addr5, addr1;
    logic [127:0] wd5, wd1, rdata5, rdata1;
    logic         bw5, bw1;
    logic [127:0] mem_m [256];
    logic [7:0]   written_q [$];
    logic [127:0] exp_rd5;
    int           n_chk, n_fail;

    data_memory_responder #(.LATENCY(5), .INDEX_BITS(8)) dut5 (
        .CLK(clk), .RESET(rst), .READ(rd5), .WRITE(wr5), .ADDRESS(addr5),
        .WRITEDATA(wd5), .READDATA(rdata5), .BUSYWAIT(bw5));
    data_memory_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
        .CLK(clk), .RESET(rst), .READ(rd1), .WRITE(wr1), .ADDRESS(addr1),
        .WRITEDATA(wd1), .READDATA(rdata1), .BUSYWAIT(bw1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One LATENCY=5 transaction: request cycle + 4 BUSY cycles + 1 ACK cycle.
    // chg_at: BUSY cycle in which ADDRESS/WRITEDATA are disturbed; rst3: reset in third BUSY cycle.
    task automatic txn5(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d,
                        input int chg_at, input logic [27:0] a2, input logic rst3, input string tag);
        logic [7:0] idx;
        idx = a[7:0];
        rd5 = rd; wr5 = wr; addr5 = a; wd5 = d;
        #1;
        chk({tag, " bw_req"}, 128'(bw5), 128'(1));
        step();
        rd5 = 1'b0; wr5 = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (k == chg_at) begin addr5 = a2; wd5 = ~d; end
            chk({tag, " bw_busy"}, 128'(bw5), 128'(1));
            chk({tag, " rd_hold"}, rdata5, exp_rd5);
            if (rst3 && k == 3) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                exp_rd5 = '0;
                chk({tag, " bw_after_rst"}, 128'(bw5), 128'(0));
                chk({tag, " rd_after_rst"}, rdata5, exp_rd5);
                return;
            end
            step();
        end
        if (wr) begin
            mem_m[idx] = d;
            written_q.push_back(idx);
        end else exp_rd5 = mem_m[idx];
        chk({tag, " bw_ack"}, 128'(bw5), 128'(0));
        chk({tag, " rdata"}, rdata5, exp_rd5);
        step();
        chk({tag, " bw_idle"}, 128'(bw5), 128'(0));
    endtask

    initial begin
        logic [127:0] v;
        logic [7:0]   ri;
        n_chk = 0; n_fail = 0;
        exp_rd5 = '0;
        rst = 1'b1;
        rd5 = 0; wr5 = 0; addr5 = '0; wd5 = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wd1 = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset bw5", 128'(bw5), 128'(0));
        chk("reset rd5", rdata5, 128'(0));
        chk("reset bw1", 128'(bw1), 128'(0));
        chk("reset rd1", rdata1, 128'(0));

        txn5(0, 1, 28'h0000003, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, '0, 0, "wr3");
        txn5(1, 0, 28'h0000003, '0, 0, '0, 0, "rd3");

        txn5(0, 1, 28'h0000105, {32{4'hA}}, 0, '0, 0, "alias_wr");
        txn5(1, 0, 28'h0000005, '0, 0, '0, 0, "alias_rd");
        chk("alias value", rdata5, {32{4'hA}});

        txn5(1, 1, 28'h0000007, {32{4'h5}}, 0, '0, 0, "both");
        txn5(1, 0, 28'h0000007, '0, 0, '0, 0, "both_rd");
        chk("both value", rdata5, {32{4'h5}});

        txn5(0, 1, 28'h0000020, {32{4'h2}}, 0, '0, 0, "pre20");
        txn5(0, 1, 28'h0000010, {32{4'h1}}, 2, 28'h0000020, 0, "chg");
        txn5(1, 0, 28'h0000010, '0, 0, '0, 0, "chg_rd10");
        txn5(1, 0, 28'h0000020, '0, 0, '0, 0, "chg_rd20");

        txn5(0, 1, 28'h0000009, {32{4'h9}}, 0, '0, 0, "pre9");
        txn5(1, 0, 28'h0000003, '0, 0, '0, 0, "rd3b");
        txn5(0, 1, 28'h0000009, {128{1'b1}}, 0, '0, 1, "rst_mid");
        txn5(1, 0, 28'h0000009, '0, 0, '0, 0, "rd9");
        chk("rst no write", rdata5, {32{4'h9}});

        v = {$urandom, $urandom, $urandom, $urandom};
        wr1 = 1; addr1 = 28'h0000002; wd1 = v;
        #1;
        chk("l1 wr bw_req", 128'(bw1), 128'(1));
        step();
        wr1 = 0;
        chk("l1 wr bw_ack", 128'(bw1), 128'(0));
        chk("l1 wr rd_hold", rdata1, 128'(0));
        step();
        chk("l1 wr bw_idle", 128'(bw1), 128'(0));
        rd1 = 1; addr1 = 28'h0000002;
        #1;
        chk("l1 rd bw1", 128'(bw1), 128'(1));
        step();
        chk("l1 rd bw2", 128'(bw1), 128'(0));
        chk("l1 rd data1", rdata1, v);
        step();
        chk("l1 rd bw3", 128'(bw1), 128'(1));
        step();
        chk("l1 rd bw4", 128'(bw1), 128'(0));
        chk("l1 rd data2", rdata1, v);
        rd1 = 0;
        step();
        chk("l1 rd bw_idle", 128'(bw1), 128'(0));

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                ri = 8'($urandom);
                v = {$urandom, $urandom, $urandom, $urandom};
                txn5($urandom_range(1, 0) == 1, 1, {20'($urandom), ri}, v, $urandom_range(4, 0), 28'($urandom), 0, "rnd_wr");
            end else begin
                ri = written_q[$urandom_range(written_q.size() - 1, 0)];
                txn5(1, 0, {20'($urandom), ri}, 128'({$urandom, $urandom}), $urandom_range(4, 0), 28'($urandom), 0, "rnd_rd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
